// File: rtl/mem_access_stage.sv
// MEM pipeline stage: performs loads/stores over a req/ack data bus, stalls the
// pipeline while the access is in flight and forwards results toward MEM/WB.
module mem_access_stage #(
  parameter int         TIMEOUT = 16,
  parameter logic [7:0] OP_LB   = 8'h20,
  parameter logic [7:0] OP_LH   = 8'h21,
  parameter logic [7:0] OP_LW   = 8'h23,
  parameter logic [7:0] OP_LBU  = 8'h24,
  parameter logic [7:0] OP_LHU  = 8'h25,
  parameter logic [7:0] OP_SB   = 8'h28,
  parameter logic [7:0] OP_SH   = 8'h29,
  parameter logic [7:0] OP_SW   = 8'h2B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic        stall_req,
  output logic        mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, next_state;
  logic [CW-1:0] counter;
  logic          err_flag;
  logic [31:0]   load_data;

  logic        is_load, is_store, is_mem, is_byte, is_half, misaligned, timeout_hit;
  logic [3:0]  sel_comb;
  logic [31:0] wdata_comb, shifted, formatted;

  // Decode the op, check alignment and build lane enables / store and load data.
  always_comb begin
    is_load  = (mem_aluop_i == OP_LB) || (mem_aluop_i == OP_LH) || (mem_aluop_i == OP_LW) ||
               (mem_aluop_i == OP_LBU) || (mem_aluop_i == OP_LHU);
    is_store = (mem_aluop_i == OP_SB) || (mem_aluop_i == OP_SH) || (mem_aluop_i == OP_SW);
    is_mem   = is_load || is_store;
    is_byte  = (mem_aluop_i == OP_LB) || (mem_aluop_i == OP_LBU) || (mem_aluop_i == OP_SB);
    is_half  = (mem_aluop_i == OP_LH) || (mem_aluop_i == OP_LHU) || (mem_aluop_i == OP_SH);
    misaligned = is_half ? mem_mem_addr_i[0] : (!is_byte && (mem_mem_addr_i[1:0] != 2'b00));
    if (is_byte) begin
      sel_comb   = 4'b0001 << mem_mem_addr_i[1:0];
      wdata_comb = {4{mem_reg2_i[7:0]}};
    end else if (is_half) begin
      sel_comb   = mem_mem_addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_comb = {2{mem_reg2_i[15:0]}};
    end else begin
      sel_comb   = 4'b1111;
      wdata_comb = mem_reg2_i;
    end
    shifted = bus_rdata >> {mem_mem_addr_i[1:0], 3'b000};
    if (mem_aluop_i == OP_LB)       formatted = {{24{shifted[7]}}, shifted[7:0]};
    else if (mem_aluop_i == OP_LBU) formatted = {24'd0, shifted[7:0]};
    else if (mem_aluop_i == OP_LH)  formatted = {{16{shifted[15]}}, shifted[15:0]};
    else if (mem_aluop_i == OP_LHU) formatted = {16'd0, shifted[15:0]};
    else                            formatted = shifted;
    timeout_hit = (counter == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state and the combinational stall / write-back outputs.
  always_comb begin
    next_state = state;
    stall_req  = 1'b0;
    mem_err    = 1'b0;
    wb_wdata   = 32'd0;
    wb_wd      = 5'd0;
    wb_wreg    = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mem) begin
          stall_req  = 1'b1;
          next_state = misaligned ? S_DONE : S_WAIT;
        end else begin
          wb_wdata = mem_wdata_i;
          wb_wd    = mem_wd_i;
          wb_wreg  = mem_wreg_i;
        end
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (bus_ack || timeout_hit) next_state = S_DONE;
      end
      S_DONE: begin
        mem_err = err_flag;
        wb_wd   = mem_wd_i;
        if (is_load && !err_flag) begin
          wb_wreg  = mem_wreg_i;
          wb_wdata = load_data;
        end
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (rst) begin
      stall_req = 1'b0;
      mem_err   = 1'b0;
      wb_wdata  = 32'd0;
      wb_wd     = 5'd0;
      wb_wreg   = 1'b0;
    end
  end

  // Bus outputs are launched from IDLE and held untouched until ack or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      err_flag  <= 1'b0;
      load_data <= 32'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          counter <= '0;
          if (is_mem && misaligned) begin
            err_flag <= 1'b1;
          end else if (is_mem) begin
            err_flag  <= 1'b0;
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_mem_addr_i[31:2], 2'b00};
            bus_sel   <= sel_comb;
            bus_wdata <= wdata_comb;
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            load_data <= formatted;
            counter   <= '0;
          end else if (timeout_hit) begin
            bus_req  <= 1'b0;
            err_flag <= 1'b1;
            counter  <= '0;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        S_DONE: err_flag <= 1'b0;
        default: err_flag <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a hand-driven bus slave.
module tb_mem_access_stage;

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_wdata_i, mem_mem_addr_i, mem_reg2_i, bus_rdata;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i, bus_ack;
  logic [7:0]  mem_aluop_i;
  logic        bus_req, bus_we, wb_wreg, stall_req, mem_err;
  logic [31:0] bus_addr, bus_wdata, wb_wdata;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;

  int compare_count  = 0;
  int mismatch_count = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_wdata_i(mem_wdata_i), .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i),
    .mem_aluop_i(mem_aluop_i), .mem_mem_addr_i(mem_mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .stall_req(stall_req), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    if (obs !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                               input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
    mem_aluop_i    = op;
    mem_mem_addr_i = addr;
    mem_reg2_i     = reg2;
    mem_wdata_i    = wdata;
    mem_wd_i       = wd;
    mem_wreg_i     = wreg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nonMem(input logic [31:0] value);
    applyStimulus(8'h00, 32'd0, 32'd0, value, 5'd5, 1'b1);
    #1;
  endtask

  // One load acknowledged on its first WAIT cycle, checking lanes and formatting.
  task automatic quickLoad(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_sel,
                           input logic [31:0] exp_data);
    step();
    applyStimulus(op, addr, 32'd0, 32'd0, 5'd2, 1'b1);
    step();
    checkOutput({tag, "_sel"}, {28'd0, bus_sel}, {28'd0, exp_sel});
    checkOutput({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
    bus_rdata = rdata;
    bus_ack   = 1'b1;
    step();
    bus_ack = 1'b0;
    checkOutput({tag, "_data"}, wb_wdata, exp_data);
    checkOutput({tag, "_wreg"}, {31'd0, wb_wreg}, 32'd1);
    step();
    nonMem(32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int high;
    bit done;
    rst = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    applyStimulus(8'h00, 32'h0, 32'h0, 32'hDEAD, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wb_wdata", wb_wdata, 32'd0);
    checkOutput("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall_req}, 32'd0);
    checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
    checkOutput("rst_mem_err", {31'd0, mem_err}, 32'd0);
    rst = 1'b0;

    // Non-memory pass-through in the same cycle
    applyStimulus(8'h00, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
    #1;
    checkOutput("nm_wdata", wb_wdata, 32'h1234);
    checkOutput("nm_wd", {27'd0, wb_wd}, 32'd5);
    checkOutput("nm_wreg", {31'd0, wb_wreg}, 32'd1);
    checkOutput("nm_stall", {31'd0, stall_req}, 32'd0);

    // LB at 0x103, ack on first WAIT cycle
    step();
    applyStimulus(OP_LB, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1);
    #1;
    checkOutput("lb_idle_stall", {31'd0, stall_req}, 32'd1);
    checkOutput("lb_idle_req", {31'd0, bus_req}, 32'd0);
    step();
    checkOutput("lb_wait_req", {31'd0, bus_req}, 32'd1);
    checkOutput("lb_wait_addr", bus_addr, 32'h100);
    checkOutput("lb_wait_sel", {28'd0, bus_sel}, 32'h8);
    checkOutput("lb_wait_we", {31'd0, bus_we}, 32'd0);
    checkOutput("lb_wait_stall", {31'd0, stall_req}, 32'd1);
    bus_rdata = 32'h8000_0000;
    bus_ack   = 1'b1;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    checkOutput("lb_done_stall", {31'd0, stall_req}, 32'd0);
    checkOutput("lb_done_wdata", wb_wdata, 32'hFFFF_FF80);
    checkOutput("lb_done_wreg", {31'd0, wb_wreg}, 32'd1);
    checkOutput("lb_done_wd", {27'd0, wb_wd}, 32'd7);
    checkOutput("lb_done_req", {31'd0, bus_req}, 32'd0);
    checkOutput("lb_done_err", {31'd0, mem_err}, 32'd0);
    step();
    nonMem(32'h5555);
    checkOutput("lb_back_idle", wb_wdata, 32'h5555);
    checkOutput("lb_back_stall", {31'd0, stall_req}, 32'd0);

    // SH at 0x202, ack on third WAIT cycle
    step();
    applyStimulus(OP_SH, 32'h202, 32'hABCD_1234, 32'h0, 5'd9, 1'b1);
    #1;
    checkOutput("sh_idle_stall", {31'd0, stall_req}, 32'd1);
    step();
    checkOutput("sh_we", {31'd0, bus_we}, 32'd1);
    checkOutput("sh_sel", {28'd0, bus_sel}, 32'hC);
    checkOutput("sh_wdata", bus_wdata, 32'h1234_1234);
    checkOutput("sh_addr", bus_addr, 32'h200);
    step();
    checkOutput("sh_wait2_req", {31'd0, bus_req}, 32'd1);
    step();
    checkOutput("sh_wait3_req", {31'd0, bus_req}, 32'd1);
    checkOutput("sh_wait3_wdata", bus_wdata, 32'h1234_1234);
    checkOutput("sh_wait3_stall", {31'd0, stall_req}, 32'd1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    checkOutput("sh_done_wreg", {31'd0, wb_wreg}, 32'd0);
    checkOutput("sh_done_wdata", wb_wdata, 32'd0);
    checkOutput("sh_done_wd", {27'd0, wb_wd}, 32'd9);
    checkOutput("sh_done_stall", {31'd0, stall_req}, 32'd0);
    checkOutput("sh_done_req", {31'd0, bus_req}, 32'd0);
    step();
    nonMem(32'h0);

    // Extension and lane coverage
    quickLoad("lhu", OP_LHU, 32'h302, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    quickLoad("lh", OP_LH, 32'h302, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    quickLoad("lb0", OP_LB, 32'h400, 32'h0000_007F, 4'b0001, 32'h0000_007F);

    // SB at offset 1
    step();
    applyStimulus(OP_SB, 32'h501, 32'h1122_335A, 32'h0, 5'd1, 1'b1);
    step();
    checkOutput("sb_sel", {28'd0, bus_sel}, 32'h2);
    checkOutput("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    nonMem(32'h0);

    // Misaligned LW: no bus access, one stall cycle, error in DONE
    step();
    applyStimulus(OP_LW, 32'h6, 32'h0, 32'h0, 5'd4, 1'b1);
    #1;
    checkOutput("mis_idle_stall", {31'd0, stall_req}, 32'd1);
    step();
    checkOutput("mis_done_req", {31'd0, bus_req}, 32'd0);
    checkOutput("mis_done_err", {31'd0, mem_err}, 32'd1);
    checkOutput("mis_done_wreg", {31'd0, wb_wreg}, 32'd0);
    checkOutput("mis_done_stall", {31'd0, stall_req}, 32'd0);
    step();
    nonMem(32'h0);
    checkOutput("mis_err_cleared", {31'd0, mem_err}, 32'd0);

    // LW with no ack: abort after TIMEOUT WAIT cycles
    step();
    applyStimulus(OP_LW, 32'h40, 32'h0, 32'h0, 5'd6, 1'b1);
    #1;
    high = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (bus_req) high++;
      else done = 1'b1;
    end
    checkOutput("to_wait_cycles", high, 32'd16);
    checkOutput("to_ended", {31'd0, done}, 32'd1);
    checkOutput("to_done_err", {31'd0, mem_err}, 32'd1);
    checkOutput("to_done_wreg", {31'd0, wb_wreg}, 32'd0);
    step();
    nonMem(32'h0);
    checkOutput("to_err_cleared", {31'd0, mem_err}, 32'd0);
    checkOutput("to_idle_stall", {31'd0, stall_req}, 32'd0);

    // Reset pulse mid-WAIT, then a late ack
    step();
    applyStimulus(OP_LW, 32'h80, 32'h0, 32'h0, 5'd8, 1'b1);
    step();
    checkOutput("rw_wait_req", {31'd0, bus_req}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    checkOutput("rw_rst_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rw_rst_stall", {31'd0, stall_req}, 32'd0);
    checkOutput("rw_rst_wreg", {31'd0, wb_wreg}, 32'd0);
    step();
    rst = 1'b0;
    nonMem(32'h77);
    bus_rdata = 32'hFFFF_FFFF;
    bus_ack   = 1'b1;
    #1;
    checkOutput("rw_idle_wdata", wb_wdata, 32'h77);
    checkOutput("rw_idle_stall", {31'd0, stall_req}, 32'd0);
    step();
    bus_ack = 1'b0;
    checkOutput("rw_late_ack_wdata", wb_wdata, 32'h77);
    checkOutput("rw_late_ack_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rw_late_ack_err", {31'd0, mem_err}, 32'd0);
    checkOutput("rw_late_ack_stall", {31'd0, stall_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
